// File: rtl/child_resp_collector_if.sv
`default_nettype none
// ============================================================================
//  Module      : child_resp_collector_if
//  Description : Bundle of the child-side response beats and the merged parent
//                channel of child_resp_collector. The collector connects to
//                the slave modport; the environment that drives the children
//                and sinks the parent channel uses the master modport.
//                Optional macro COLLECTOR_TAG_EN adds par_idx (source child
//                index) to the bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface child_resp_collector_if #(
  parameter int NUM_CHILD = 10,
  parameter int DATA_W    = 16
`ifdef COLLECTOR_TAG_EN
  ,
  parameter int IDX_W     = 4
`endif
);

  // Child -> collector response beats
  logic [NUM_CHILD-1:0]        child_valid;
  logic [NUM_CHILD*DATA_W-1:0] child_data;
  logic [NUM_CHILD-1:0]        child_ready;

  // Collector -> parent merged channel
  logic                        par_valid;
  logic [DATA_W-1:0]           par_data;
  logic                        par_ready;

  // Status
  logic [15:0]                 xfer_cnt;
  logic                        busy;

`ifdef COLLECTOR_TAG_EN
  logic [IDX_W-1:0]            par_idx;

  modport master (
    output child_valid, child_data, par_ready,
    input  child_ready, par_valid, par_data, xfer_cnt, busy, par_idx
  );

  modport slave (
    input  child_valid, child_data, par_ready,
    output child_ready, par_valid, par_data, xfer_cnt, busy, par_idx
  );
`else
  modport master (
    output child_valid, child_data, par_ready,
    input  child_ready, par_valid, par_data, xfer_cnt, busy
  );

  modport slave (
    input  child_valid, child_data, par_ready,
    output child_ready, par_valid, par_data, xfer_cnt, busy
  );
`endif

endinterface : child_resp_collector_if
`default_nettype wire

// File: rtl/child_resp_collector.sv
`default_nettype none
// ============================================================================
//  Module      : child_resp_collector
//  Description : Merges valid/ready response beats from NUM_CHILD children
//                onto one parent channel. A round-robin arbiter picks one
//                requesting child per cycle and pushes its payload into a
//                2-entry FIFO whose head drives the parent channel. The FIFO
//                output is fully registered, so there is no combinational
//                child-to-parent path and one beat per cycle is sustained.
//                Optional macro COLLECTOR_TAG_EN stores the source child
//                index with each entry and presents it on par_idx.
//  Revision    : 1.0 - initial release
// ============================================================================
module child_resp_collector #(
  parameter int NUM_CHILD = 10,   // number of child channels (2..16)
  parameter int DATA_W    = 16,   // payload width per beat
  parameter int IDX_W     = 4     // child index width, 2**IDX_W >= NUM_CHILD
) (
  input wire                      clk,
  input wire                      rst,
  child_resp_collector_if.slave   io_col
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
`ifdef COLLECTOR_TAG_EN
  localparam int c_ENTRY_W = DATA_W + IDX_W;   // {index, payload}
`else
  localparam int c_ENTRY_W = DATA_W;           // payload only
`endif
  localparam int               c_SEL_N    = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_CHILD - 1);
  localparam logic [IDX_W:0]   c_NUM_EXT  = (IDX_W + 1)'(NUM_CHILD);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0]     r_ptr;          // round-robin start position
  logic [c_ENTRY_W-1:0] r_mem [2];      // FIFO storage
  logic                 r_wr_ptr;       // FIFO tail slot
  logic                 r_rd_ptr;       // FIFO head slot
  logic [1:0]           r_count;        // FIFO occupancy 0..2
  logic [c_ENTRY_W-1:0] r_last;         // last popped entry, shown when empty
  logic [15:0]          r_xfer_cnt;     // accepted-beat counter

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [c_SEL_N-1:0]   w_valid_pad;    // child_valid padded to index range
  logic [IDX_W-1:0]     w_sel;          // arbitration winner
  logic [DATA_W-1:0]    w_sel_data;     // winner's payload
  logic [c_ENTRY_W-1:0] w_wr_entry;     // entry written on push
  logic [c_ENTRY_W-1:0] w_head;         // FIFO head entry
  logic [c_ENTRY_W-1:0] w_out;          // entry presented to the parent
  logic                 w_any;          // some child is requesting
  logic                 w_space;        // a push can be taken this cycle
  logic                 w_push;         // beat accepted from w_sel
  logic                 w_pop;          // beat taken by the parent

  assign w_valid_pad = c_SEL_N'(io_col.child_valid);
  assign w_any       = |io_col.child_valid;

  // A pop is only possible with data present; par_ready is ignored when empty.
  assign w_pop   = (r_count != 2'd0) && io_col.par_ready;

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_space = (r_count < 2'd2) || ((r_count == 2'd2) && w_pop);

  // Reset blocks every grant so no child sees a handshake during reset.
  assign w_push  = !rst && w_any && w_space;

  // Round-robin pick: first requester scanning from r_ptr upward with wrap.
  always_comb begin
    logic [IDX_W:0] w_cand;
    logic           w_found;
    w_sel   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NUM_CHILD; k++) begin
      w_cand = {1'b0, r_ptr} + (IDX_W + 1)'(k);
      if (w_cand >= c_NUM_EXT) begin
        w_cand = w_cand - c_NUM_EXT;
      end
      if (!w_found && w_valid_pad[w_cand[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[IDX_W-1:0];
      end
    end
  end

  // Payload mux for the selected child.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_CHILD; i++) begin
      if (w_sel == IDX_W'(i)) begin
        w_sel_data = io_col.child_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // One-hot accept back to the granted child; all-zero when no push.
  always_comb begin
    io_col.child_ready = '0;
    for (int i = 0; i < NUM_CHILD; i++) begin
      io_col.child_ready[i] = w_push && (w_sel == IDX_W'(i));
    end
  end

`ifdef COLLECTOR_TAG_EN
  assign w_wr_entry = {w_sel, w_sel_data};
`else
  assign w_wr_entry = w_sel_data;
`endif

  // --------------------------------------------------------------------------
  // Parent-side outputs: FIFO head while occupied, last popped entry otherwise
  // --------------------------------------------------------------------------
  assign w_head           = r_mem[r_rd_ptr];
  assign w_out            = (r_count != 2'd0) ? w_head : r_last;
  assign io_col.par_valid = (r_count != 2'd0);
  assign io_col.par_data  = w_out[DATA_W-1:0];
`ifdef COLLECTOR_TAG_EN
  assign io_col.par_idx   = w_out[c_ENTRY_W-1 -: IDX_W];
`endif
  assign io_col.xfer_cnt  = r_xfer_cnt;
  assign io_col.busy      = (r_count != 2'd0) || w_any;

  // Arbitration pointer: move past the winner on a push, hold otherwise so a
  // lone requester keeps first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_push) begin
      r_ptr <= (w_sel == c_LAST_IDX) ? '0 : w_sel + IDX_W'(1);
    end
  end

  // FIFO storage and tail pointer; reset clears contents so stale beats
  // can never reappear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
      r_wr_ptr        <= ~r_wr_ptr;
    end
  end

  // FIFO head pointer and the hold register used while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= 1'b0;
      r_last   <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= ~r_rd_ptr;
      r_last   <= w_head;
    end
  end

  // FIFO occupancy; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Accepted-beat counter, free-running with natural 16-bit wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_cnt <= 16'd0;
    end else if (w_push) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

endmodule : child_resp_collector
`default_nettype wire

// File: tb/tb_child_resp_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_child_resp_collector
//  Description : Self-checking bench for child_resp_collector. Expected beats
//                are queued when stimulus is applied and compared against the
//                parent channel whenever a beat is taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_child_resp_collector;

  localparam int NUM_CHILD = 10;
  localparam int DATA_W    = 16;
  localparam int IDX_W     = 4;
  localparam int ENT_W     = IDX_W + DATA_W;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [ENT_W-1:0] sb_q [$];
  logic [ENT_W-1:0] m_exp;

  always #5 clk = ~clk;

`ifdef COLLECTOR_TAG_EN
  child_resp_collector_if #(.NUM_CHILD(NUM_CHILD), .DATA_W(DATA_W), .IDX_W(IDX_W)) io_col ();
`else
  child_resp_collector_if #(.NUM_CHILD(NUM_CHILD), .DATA_W(DATA_W)) io_col ();
`endif

  child_resp_collector #(.NUM_CHILD(NUM_CHILD), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_col (io_col)
  );

  // Scoreboard: every beat taken by the parent must match the queue head.
  always @(negedge clk) begin
    if (!rst && io_col.par_valid && io_col.par_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got data=%h, expected no beat", io_col.par_data);
      end else begin
        m_exp = sb_q.pop_front();
        if (io_col.par_data !== m_exp[DATA_W-1:0]) begin
          errors++;
          $display("FAIL beat_data: got %h, expected %h", io_col.par_data, m_exp[DATA_W-1:0]);
        end
`ifdef COLLECTOR_TAG_EN
        checks++;
        if (io_col.par_idx !== m_exp[ENT_W-1 -: IDX_W]) begin
          errors++;
          $display("FAIL beat_idx: got %0d, expected %0d", io_col.par_idx, m_exp[ENT_W-1 -: IDX_W]);
        end
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DATA_W-1:0] v);
    io_col.child_data[i*DATA_W +: DATA_W] = v;
  endtask

  task automatic exp_push(input int i, input logic [DATA_W-1:0] v);
    sb_q.push_back({IDX_W'(i), v});
  endtask

  // Wait for the scoreboard to empty; ok=0 if the bound expires.
  task automatic wait_drain(output bit ok);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    ok = (sb_q.size() == 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    io_col.child_valid = '0;
    io_col.par_ready   = 1'b0;
    tick();
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1;
    io_col.child_valid = '1;
    io_col.par_ready   = 1'b1;
    for (int i = 0; i < NUM_CHILD; i++) set_data(i, 16'hA000 + 16'(i));
    tick();
    tick();
    @(negedge clk);
    checks++; if (io_col.child_ready !== '0) begin errors++; $display("FAIL rst_ready: got %b, expected 0", io_col.child_ready); end
    checks++; if (io_col.par_valid !== 1'b0) begin errors++; $display("FAIL rst_par_valid: got %b, expected 0", io_col.par_valid); end
    checks++; if (io_col.par_data !== 16'h0) begin errors++; $display("FAIL rst_par_data: got %h, expected 0", io_col.par_data); end
    checks++; if (io_col.xfer_cnt !== 16'h0) begin errors++; $display("FAIL rst_xfer_cnt: got %h, expected 0", io_col.xfer_cnt); end
    checks++; if (io_col.busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b, expected 1", io_col.busy); end
`ifdef COLLECTOR_TAG_EN
    checks++; if (io_col.par_idx !== '0) begin errors++; $display("FAIL rst_par_idx: got %0d, expected 0", io_col.par_idx); end
`endif
    for (int k = 0; k <= NUM_CHILD; k++) exp_push(k % NUM_CHILD, 16'hA000 + 16'(k % NUM_CHILD));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k <= NUM_CHILD; k++) begin
      @(negedge clk);
      checks++;
      if (io_col.child_ready !== (NUM_CHILD'(1) << (k % NUM_CHILD))) begin
        errors++;
        $display("FAIL rr_order: got %b, expected child %0d", io_col.child_ready, k % NUM_CHILD);
      end
      tick();
    end
    io_col.child_valid = '0;
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_drain: got %0d pending, expected 0", sb_q.size()); end
    @(negedge clk);
    checks++; if (io_col.xfer_cnt !== 16'd11) begin errors++; $display("FAIL rr_xfer_cnt: got %0d, expected 11", io_col.xfer_cnt); end
    checks++; if (io_col.par_valid !== 1'b0) begin errors++; $display("FAIL rr_empty: got %b, expected 0", io_col.par_valid); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    set_data(3, 16'h0003);
    set_data(7, 16'h0007);
    io_col.child_valid = (NUM_CHILD'(1) << 3) | (NUM_CHILD'(1) << 7);
    exp_push(3, 16'h0003);
    exp_push(7, 16'h0007);
    @(negedge clk);
    checks++; if (io_col.child_ready !== (NUM_CHILD'(1) << 3)) begin errors++; $display("FAIL bp_grant3: got %b, expected child 3", io_col.child_ready); end
    tick();
    io_col.child_valid[3] = 1'b0;
    @(negedge clk);
    checks++; if (io_col.child_ready !== (NUM_CHILD'(1) << 7)) begin errors++; $display("FAIL bp_grant7: got %b, expected child 7", io_col.child_ready); end
    checks++; if (io_col.par_data !== 16'h0003) begin errors++; $display("FAIL bp_head1: got %h, expected 0003", io_col.par_data); end
    tick();
    io_col.child_valid[7] = 1'b0;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      checks++; if (io_col.child_ready !== '0) begin errors++; $display("FAIL bp_ready_off: got %b, expected 0", io_col.child_ready); end
      checks++; if (io_col.par_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold: got %b, expected 1", io_col.par_valid); end
      checks++; if (io_col.par_data !== 16'h0003) begin errors++; $display("FAIL bp_data_hold: got %h, expected 0003", io_col.par_data); end
`ifdef COLLECTOR_TAG_EN
      checks++; if (io_col.par_idx !== 4'd3) begin errors++; $display("FAIL bp_idx_hold: got %0d, expected 3", io_col.par_idx); end
`endif
      tick();
    end
    io_col.par_ready = 1'b1;
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain: got %0d pending, expected 0", sb_q.size()); end
    @(negedge clk);
    checks++; if (io_col.xfer_cnt !== 16'd2) begin errors++; $display("FAIL bp_xfer_cnt: got %0d, expected 2", io_col.xfer_cnt); end
    checks++; if (io_col.par_data !== 16'h0007) begin errors++; $display("FAIL bp_last_hold: got %h, expected 0007", io_col.par_data); end
  endtask

  task automatic test_full_pop();
    bit ok;
    do_reset();
    set_data(2, 16'h0022);
    set_data(4, 16'h0044);
    set_data(5, 16'h0055);
    io_col.child_valid = (NUM_CHILD'(1) << 2) | (NUM_CHILD'(1) << 4);
    exp_push(2, 16'h0022);
    exp_push(4, 16'h0044);
    tick();
    io_col.child_valid[2] = 1'b0;
    tick();
    io_col.child_valid[4] = 1'b0;
    io_col.child_valid[5] = 1'b1;
    @(negedge clk);
    checks++; if (io_col.child_ready !== '0) begin errors++; $display("FAIL full_block: got %b, expected 0", io_col.child_ready); end
    checks++; if (io_col.par_data !== 16'h0022) begin errors++; $display("FAIL full_head: got %h, expected 0022", io_col.par_data); end
    tick();
    io_col.par_ready = 1'b1;
    exp_push(5, 16'h0055);
    @(negedge clk);
    checks++; if (io_col.child_ready !== (NUM_CHILD'(1) << 5)) begin errors++; $display("FAIL full_pop_grant: got %b, expected child 5", io_col.child_ready); end
    tick();
    io_col.child_valid[5] = 1'b0;
    @(negedge clk);
    checks++; if (io_col.par_data !== 16'h0044) begin errors++; $display("FAIL full_pop_head: got %h, expected 0044", io_col.par_data); end
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_drain: got %0d pending, expected 0", sb_q.size()); end
    @(negedge clk);
    checks++; if (io_col.xfer_cnt !== 16'd3) begin errors++; $display("FAIL full_xfer_cnt: got %0d, expected 3", io_col.xfer_cnt); end
    checks++; if (io_col.par_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got %b, expected 0", io_col.par_valid); end
  endtask

  task automatic test_ptr_wrap();
    bit ok;
    do_reset();
    io_col.par_ready = 1'b1;
    set_data(9, 16'h0099);
    set_data(0, 16'h0100);
    set_data(5, 16'h0505);
    io_col.child_valid = NUM_CHILD'(1) << 9;
    exp_push(9, 16'h0099);
    @(negedge clk);
    checks++; if (io_col.child_ready !== (NUM_CHILD'(1) << 9)) begin errors++; $display("FAIL wrap_grant9: got %b, expected child 9", io_col.child_ready); end
    tick();
    io_col.child_valid = (NUM_CHILD'(1) << 0) | (NUM_CHILD'(1) << 5) | (NUM_CHILD'(1) << 9);
    exp_push(0, 16'h0100);
    exp_push(5, 16'h0505);
    exp_push(9, 16'h0099);
    @(negedge clk);
    checks++; if (io_col.child_ready !== (NUM_CHILD'(1) << 0)) begin errors++; $display("FAIL wrap_grant0: got %b, expected child 0", io_col.child_ready); end
    tick();
    io_col.child_valid[0] = 1'b0;
    @(negedge clk);
    checks++; if (io_col.child_ready !== (NUM_CHILD'(1) << 5)) begin errors++; $display("FAIL wrap_grant5: got %b, expected child 5", io_col.child_ready); end
    tick();
    io_col.child_valid[5] = 1'b0;
    @(negedge clk);
    checks++; if (io_col.child_ready !== (NUM_CHILD'(1) << 9)) begin errors++; $display("FAIL wrap_grant9b: got %b, expected child 9", io_col.child_ready); end
    tick();
    io_col.child_valid = '0;
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_drain: got %0d pending, expected 0", sb_q.size()); end
  endtask

  task automatic test_counter_wrap();
    bit ok;
    do_reset();
    io_col.par_ready = 1'b1;
    for (int i = 0; i < NUM_CHILD; i++) set_data(i, 16'hC000 + 16'(i));
    io_col.child_valid = '1;
    for (int n = 0; n < 65535; n++) begin
      exp_push(n % NUM_CHILD, 16'hC000 + 16'(n % NUM_CHILD));
      tick();
    end
    io_col.child_valid = '0;
    @(negedge clk);
    checks++; if (io_col.xfer_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_preload: got %h, expected ffff", io_col.xfer_cnt); end
    tick();
    io_col.child_valid = '1;
    exp_push(65535 % NUM_CHILD, 16'hC000 + 16'(65535 % NUM_CHILD));
    @(negedge clk);
    checks++; if (io_col.child_ready !== (NUM_CHILD'(1) << (65535 % NUM_CHILD))) begin errors++; $display("FAIL cnt_grant: got %b, expected child 5", io_col.child_ready); end
    tick();
    io_col.child_valid = '0;
    @(negedge clk);
    checks++; if (io_col.xfer_cnt !== 16'h0000) begin errors++; $display("FAIL cnt_wrap: got %h, expected 0000", io_col.xfer_cnt); end
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL cnt_drain: got %0d pending, expected 0", sb_q.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_data(1, 16'h0EE1);
    set_data(2, 16'h0EE2);
    set_data(3, 16'h0EE3);
    io_col.child_valid = (NUM_CHILD'(1) << 1) | (NUM_CHILD'(1) << 2);
    tick();
    tick();
    io_col.child_valid = '0;
    @(negedge clk);
    checks++; if (io_col.par_valid !== 1'b1) begin errors++; $display("FAIL mid_filled: got %b, expected 1", io_col.par_valid); end
    checks++; if (io_col.par_data !== 16'h0EE1) begin errors++; $display("FAIL mid_head: got %h, expected 0ee1", io_col.par_data); end
    tick();
    rst = 1'b1;
    io_col.par_ready   = 1'b1;
    io_col.child_valid = NUM_CHILD'(1) << 3;
    @(negedge clk);
    checks++; if (io_col.child_ready !== '0) begin errors++; $display("FAIL mid_rst_ready: got %b, expected 0", io_col.child_ready); end
    tick();
    rst = 1'b0;
    io_col.child_valid = '0;
    @(negedge clk);
    checks++; if (io_col.par_data !== 16'h0) begin errors++; $display("FAIL mid_par_data: got %h, expected 0", io_col.par_data); end
    checks++; if (io_col.xfer_cnt !== 16'h0) begin errors++; $display("FAIL mid_xfer_cnt: got %h, expected 0", io_col.xfer_cnt); end
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      checks++; if (io_col.par_valid !== 1'b0) begin errors++; $display("FAIL mid_no_beat: got %b, expected 0", io_col.par_valid); end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    io_col.child_valid = '0;
    io_col.child_data  = '0;
    io_col.par_ready   = 1'b0;
    test_reset();
    test_backpressure();
    test_full_pop();
    test_ptr_wrap();
    test_counter_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_child_resp_collector
`default_nettype wire

// File: doc/child_resp_collector.md
Name: child_resp_collector

Overview:
- Upstream-direction counterpart of the 10-way instance fan-out tree used in the hierarchy test modules.
- Collects valid/ready response beats from NUM_CHILD child instances and merges them onto a single parent channel.
- Uses round-robin arbitration and a 2-entry output FIFO.
- Sits one level above the children, so parent-to-child broadcast has a matching child-to-parent return path.

Parameters:
NUM_CHILD, 10, number of child channels (2..16)
DATA_W, 16, payload width per child beat
IDX_W, 4, width of child index; must satisfy 2**IDX_W >= NUM_CHILD

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
child_valid  input  NUM_CHILD  per-child beat valid
child_data  input  NUM_CHILD*DATA_W  per-child payload; child i occupies bits [i*DATA_W +: DATA_W]
child_ready  output  NUM_CHILD  per-child accept; at most one bit set per cycle
par_valid  output  1  parent beat valid
par_data  output  DATA_W  parent payload (FIFO head)
par_ready  input  1  parent accept
xfer_cnt  output  16  count of beats accepted from children; wraps at 16'hFFFF -> 0
busy  output  1  high when FIFO count != 0 or any child_valid is high

Behaviour:
- Reset values (rst=1 at a clock edge):
  - ptr=0, fifo count=0, par_valid=0, par_data=0, xfer_cnt=0.
  - child_ready is forced to all-0 while rst is high.
  - Reset asserted mid-operation discards all FIFO contents; no beat is presented afterwards.
- Space condition: space = (count<2) || (count==2 && par_valid && par_ready).
- Selection (combinational):
  - sel = first index i, scanning ptr, ptr+1, ..., NUM_CHILD-1, 0, ..., ptr-1, with child_valid[i]=1.
  - child_ready[sel]=1 only if space and some child_valid is set; all other bits 0.
  - child_ready may depend on child_valid (valid never depends on ready).
- Push: child_valid[sel] & child_ready[sel] at an edge. Then:
  - child_data slice sel is written to the FIFO tail.
  - ptr <= (sel==NUM_CHILD-1) ? 0 : sel+1.
  - xfer_cnt increments.
- No push: ptr holds, so a lone requester is not rotated away.
- Pop: par_valid & par_ready at an edge removes the FIFO head.
- FIFO: 2 entries, circular read/write pointers.
  - par_valid = (count!=0); par_data = head entry.
  - par_data holds its value while par_valid=1 and par_ready=0.
  - When empty, par_data holds the last popped value (0 after reset).
- Latency: beat accepted at edge N appears on par_valid/par_data after edge N (one cycle); there is no combinational child-to-parent path.
- Simultaneous push and pop:
  - count unchanged; allowed at count 1 and count 2.
  - At count 2 the pop frees the slot in the same cycle.
- Full condition: count==2 and no pop -> child_ready all-0; children must hold valid and data stable.
- Empty condition: pop is impossible; par_ready is ignored.
- Throughput: 1 beat/cycle sustained when par_ready stays high.
- Fairness: with all children continuously valid, grant order is 0,1,...,NUM_CHILD-1,0,...; no child waits more than NUM_CHILD-1 grants.

Optional Feature:
COLLECTOR_TAG_EN
- Defined:
  - Adds output port par_idx [IDX_W] carrying the source child index.
  - The index is stored alongside data in each FIFO entry (entry width DATA_W+IDX_W).
  - par_idx resets to 0 and follows the same hold rules as par_data.
- Undefined:
  - par_idx port does not exist; FIFO width is DATA_W.
  - All other behaviour is identical.

Test Plan:
1. Reset check: rst=1 for 2 cycles, all child_valid=1 -> child_ready=0, par_valid=0, xfer_cnt=0. Then release rst with all children valid and par_ready=1 -> par_data sequence is child 0,1,2,...,9,0 payloads. With COLLECTOR_TAG_EN, par_idx follows 0..9,0.
2. Backpressure: par_ready=0, children 3 and 7 valid (data 16'h0003, 16'h0007) -> two pushes, then child_ready=0 and par_valid=1 with par_data=16'h0003 held. Raise par_ready -> 16'h0003 then 16'h0007. xfer_cnt ends at 2.
3. Full with simultaneous pop: count=2, par_ready=1, child 5 valid -> child_ready[5]=1 in the same cycle; count stays 2; no beat lost or duplicated.
4. Pointer wrap: only child 9 valid once, then only child 0 valid -> after the child 9 grant ptr=0, and child 0 is granted in the next cycle.
5. Counter wrap: preload via 65535 accepted beats, then one more -> xfer_cnt=0.
6. Reset mid-operation: FIFO holding 2 beats, assert rst for 1 cycle -> par_valid=0 after the edge, and the old beats never appear.
